// File: rtl/ssd_scan_driver.sv
// Four-digit seven-segment scan driver.
// A two-state double-dabble engine converts the 13-bit binary value to four
// BCD digits. A free-running prescaler multiplexes those digits onto one
// common-anode display through registered anode and cathode outputs.
module ssd_scan_driver #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] value,
  input  logic        load,
  output logic        busy,
  output logic [15:0] digits,
  output logic [3:0]  anode,
  output logic [6:0]  cathode
);

  localparam logic [19:0] PRESC_MAX = 20'(SCAN_DIV - 1);

  typedef enum logic {StIdle, StConv} state_t;

  state_t      state_q, state_d;
  logic [12:0] cap_q, cap_d;
  logic [12:0] bin_q, bin_d;
  logic [15:0] scratch_q, scratch_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic [15:0] adj;

  logic [19:0] presc_q;
  logic [1:0]  idx_q;
  logic [3:0]  anode_q, anode_d;
  logic [6:0]  cathode_q, cathode_d;
  logic [3:0]  blank;
  logic [3:0]  sel_digit;

  // Segment pattern {g,f,e,d,c,b,a}, active low; non-decimal codes are dark.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Add-3 correction on every BCD nibble that would overflow on the next shift.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM next-state: capture in idle, shift-and-adjust while converting.
  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    digits_d  = digits_q;
    unique case (state_q)
      StIdle: begin
        if (load || (value != cap_q)) begin
          cap_d     = value;
          bin_d     = value;
          scratch_d = 16'h0000;
          cnt_d     = 4'd13;
          state_d   = StConv;
        end
      end
      StConv: begin
        scratch_d = {adj[14:0], bin_q[12]};
        bin_d     = {bin_q[11:0], 1'b0};
        cnt_d     = cnt_q - 4'd1;
        // Last iteration: publish the whole result at once.
        if (cnt_q == 4'd1) begin
          digits_d = {adj[14:0], bin_q[12]};
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Conversion state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cap_q     <= '0;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
    end
  end

  // Scan prescaler and digit index; runs regardless of conversion activity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_q <= '0;
      idx_q   <= idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + 20'd1;
    end
  end

  // Leading-zero blanking mask and the digit selected by the scan index.
  always_comb begin
    blank = 4'b0000;
    if (BLANK_LZ) begin
      blank[3] = (digits_q[15:12] == 4'd0);
      blank[2] = blank[3] && (digits_q[11:8] == 4'd0);
      blank[1] = blank[2] && (digits_q[7:4] == 4'd0);
    end
    sel_digit = digits_q[4*idx_q +: 4];
  end

  // Next anode and cathode patterns for the current index.
  always_comb begin
    anode_d   = 4'b1111;
    cathode_d = 7'b1111111;
    unique case (idx_q)
      2'd0:    anode_d = 4'b1110;
      2'd1:    anode_d = 4'b1101;
      2'd2:    anode_d = 4'b1011;
      default: anode_d = 4'b0111;
    endcase
    if (!blank[idx_q]) begin
      cathode_d = seg7(sel_digit);
    end
  end

  // Registered display outputs so the pins never see decode glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode_q   <= 4'b1111;
      cathode_q <= 7'b1111111;
    end else begin
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign busy    = (state_q == StConv);
  assign digits  = digits_q;
  assign anode   = anode_q;
  assign cathode = cathode_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed testbench for ssd_scan_driver with a fast scan rate.
module tb_ssd_scan_driver;

  logic        clk;
  logic        reset;
  logic [12:0] value;
  logic        load;
  logic        busy;
  logic [15:0] digits;
  logic [3:0]  anode;
  logic [6:0]  cathode;

  int vectors;
  int miscompares;

  ssd_scan_driver #(
    .SCAN_DIV(4),
    .BLANK_LZ(1'b1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .value  (value),
    .load   (load),
    .busy   (busy),
    .digits (digits),
    .anode  (anode),
    .cathode(cathode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one conversion; report busy length and whether digits moved while busy.
  task automatic wait_conv(output int n, output bit changed);
    logic [15:0] d0;
    d0 = digits;
    n = 0;
    changed = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      load = 1'b0;
      if (busy) begin
        n++;
        if (digits !== d0) changed = 1'b1;
      end else if (n > 0) begin
        return;
      end
    end
    n = -1;
  endtask

  task automatic test_reset();
    int nbusy;
    value = 13'd0;
    load  = 1'b0;
    reset = 1'b1;
    #3;
    vectors++;
    if (busy !== 1'b0 || digits !== 16'h0000) begin
      $display("FAIL reset_hold: busy=%b digits=%h, want 0 0000", busy, digits);
      miscompares++;
    end
    vectors++;
    if (anode !== 4'b1111 || cathode !== 7'b1111111) begin
      $display("FAIL reset_outs: anode=%b cathode=%b, want 1111 1111111", anode, cathode);
      miscompares++;
    end
    tick();
    tick();
    reset = 1'b0;
    nbusy = 0;
    for (int n = 1; n <= 17; n++) begin
      tick();
      if (busy) nbusy++;
      if (n == 1) begin
        vectors++;
        if (anode !== 4'b1110 || cathode !== 7'b1000000) begin
          $display("FAIL release_first: anode=%b cathode=%b, want 1110 1000000", anode, cathode);
          miscompares++;
        end
      end
      if (n == 5 || n == 9 || n == 13) begin
        vectors++;
        if (cathode !== 7'b1111111) begin
          $display("FAIL zero_blank_%0d: cathode=%b, want 1111111", n, cathode);
          miscompares++;
        end
      end
      if (n == 17) begin
        vectors++;
        if (anode !== 4'b1110 || cathode !== 7'b1000000) begin
          $display("FAIL zero_wrap: anode=%b cathode=%b, want 1110 1000000", anode, cathode);
          miscompares++;
        end
      end
    end
    vectors++;
    if (nbusy !== 0 || digits !== 16'h0000) begin
      $display("FAIL zero_idle: busy cycles=%0d digits=%h, want 0 0000", nbusy, digits);
      miscompares++;
    end
  endtask

  task automatic test_max_value();
    int n;
    bit changed;
    value = 13'd8191;
    wait_conv(n, changed);
    vectors++;
    if (n !== 13) begin
      $display("FAIL max_busy_len: got %0d cycles, want 13", n);
      miscompares++;
    end
    vectors++;
    if (digits !== 16'h8191 || busy !== 1'b0 || changed) begin
      $display("FAIL max_digits: digits=%h busy=%b partial=%b, want 8191 0 0",
               digits, busy, changed);
      miscompares++;
    end
  endtask

  task automatic test_change_mid_conv();
    int k;
    int n;
    bit changed;
    value = 13'd1234;
    k = 0;
    for (int i = 0; i < 40 && k < 5; i++) begin
      tick();
      if (busy) k++;
    end
    value = 13'd57;
    for (int i = 0; i < 40 && busy; i++) begin
      tick();
      if (busy) k++;
    end
    vectors++;
    if (k !== 13 || digits !== 16'h1234) begin
      $display("FAIL mid_change_first: cycles=%0d digits=%h, want 13 1234", k, digits);
      miscompares++;
    end
    tick();
    vectors++;
    if (busy !== 1'b1) begin
      $display("FAIL mid_change_restart: busy=%b, want 1", busy);
      miscompares++;
    end
    n = 1;
    for (int i = 0; i < 40 && busy; i++) begin
      tick();
      if (busy) n++;
    end
    vectors++;
    if (n !== 13 || digits !== 16'h0057) begin
      $display("FAIL mid_change_second: cycles=%0d digits=%h, want 13 0057", n, digits);
      miscompares++;
    end
  endtask

  task automatic test_load_same();
    int n;
    bit changed;
    value = 13'd42;
    wait_conv(n, changed);
    vectors++;
    if (digits !== 16'h0042) begin
      $display("FAIL load_setup: digits=%h, want 0042", digits);
      miscompares++;
    end
    load = 1'b1;
    wait_conv(n, changed);
    vectors++;
    if (n !== 13) begin
      $display("FAIL load_busy_len: got %0d cycles, want 13", n);
      miscompares++;
    end
    vectors++;
    if (changed || digits !== 16'h0042) begin
      $display("FAIL load_digits: partial=%b digits=%h, want 0 0042", changed, digits);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_conv();
    int k;
    int n;
    bit changed;
    value = 13'd999;
    k = 0;
    for (int i = 0; i < 40 && k < 6; i++) begin
      tick();
      if (busy) k++;
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || digits !== 16'h0000) begin
      $display("FAIL abort_async: busy=%b digits=%h, want 0 0000", busy, digits);
      miscompares++;
    end
    tick();
    tick();
    reset = 1'b0;
    wait_conv(n, changed);
    vectors++;
    if (n !== 13 || digits !== 16'h0999) begin
      $display("FAIL abort_reconv: cycles=%0d digits=%h, want 13 0999", n, digits);
      miscompares++;
    end
  endtask

  task automatic test_scan();
    value = 13'd507;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      tick();
      if (n == 1) begin
        vectors++;
        if (busy !== 1'b1 || anode !== 4'b1110 || cathode !== 7'b1000000) begin
          $display("FAIL scan_first: busy=%b anode=%b cathode=%b, want 1 1110 1000000",
                   busy, anode, cathode);
          miscompares++;
        end
      end
      if (n == 17) begin
        vectors++;
        if (digits !== 16'h0507 || anode !== 4'b1110 || cathode !== 7'b1111000) begin
          $display("FAIL scan_ones: digits=%h anode=%b cathode=%b, want 0507 1110 1111000",
                   digits, anode, cathode);
          miscompares++;
        end
      end
      if (n == 20) begin
        vectors++;
        if (anode !== 4'b1110) begin
          $display("FAIL scan_hold: anode=%b, want 1110", anode);
          miscompares++;
        end
      end
      if (n == 21) begin
        vectors++;
        if (anode !== 4'b1101 || cathode !== 7'b1000000) begin
          $display("FAIL scan_tens: anode=%b cathode=%b, want 1101 1000000", anode, cathode);
          miscompares++;
        end
      end
      if (n == 25) begin
        vectors++;
        if (anode !== 4'b1011 || cathode !== 7'b0010010) begin
          $display("FAIL scan_hundreds: anode=%b cathode=%b, want 1011 0010010", anode, cathode);
          miscompares++;
        end
      end
      if (n == 29) begin
        vectors++;
        if (anode !== 4'b0111 || cathode !== 7'b1111111) begin
          $display("FAIL scan_thousands: anode=%b cathode=%b, want 0111 1111111", anode, cathode);
          miscompares++;
        end
      end
      if (n == 33) begin
        vectors++;
        if (anode !== 4'b1110 || cathode !== 7'b1111000) begin
          $display("FAIL scan_wrap: anode=%b cathode=%b, want 1110 1111000", anode, cathode);
          miscompares++;
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    value       = 13'd0;
    load        = 1'b0;
    test_reset();
    test_max_value();
    test_change_mid_conv();
    test_load_same();
    test_reset_mid_conv();
    test_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
